// File: rtl/ftdi_pkg.sv
// Shared definitions for the FTDI-style FIFO responder: bus FSM encoding,
// error flag positions and default geometry.
package ftdi_pkg;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned ERR_W          = 3;
  localparam int unsigned DEFAULT_DEPTH  = 16;
  localparam int unsigned DEFAULT_RD_LAT = 1;

  localparam int unsigned ERR_OVERFLOW  = 0;
  localparam int unsigned ERR_UNDERFLOW = 1;
  localparam int unsigned ERR_CONFLICT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_DRIVE = 3'd2,
    ST_RD_RECOV = 3'd3,
    ST_WR_HOLD  = 3'd4
  } ftdi_state_t;

endpackage

// File: rtl/ftdi_fifo_responder_if.sv
// Local byte streams of the responder: push toward the peer, pop of bytes the peer wrote.
interface ftdi_fifo_responder_if;
  import ftdi_pkg::*;

  logic [DATA_W-1:0] in_push_data;
  logic              in_push_valid;
  logic              out_push_ready;
  logic [DATA_W-1:0] out_pop_data;
  logic              out_pop_valid;
  logic              in_pop_ready;

  modport slave (
    input  in_push_data, in_push_valid, in_pop_ready,
    output out_push_ready, out_pop_data, out_pop_valid
  );

  modport master (
    output in_push_data, in_push_valid, in_pop_ready,
    input  out_push_ready, out_pop_data, out_pop_valid
  );

endinterface

// File: rtl/ftdi_sync_fifo.sv
// Single-clock FIFO with occupancy count; head is read combinationally from storage.
module ftdi_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ftdi_fifo_responder.sv
// FTDI-style async FIFO peer: RX bytes are read out over a shared tri-state bus,
// bytes the peer writes land in a TX FIFO for local consumption.
module ftdi_fifo_responder
  import ftdi_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned RD_LAT = DEFAULT_RD_LAT
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  output logic                 out_ftdi_txe,
  output logic                 out_ftdi_rxf,
  input  logic                 in_ftdi_rd,
  input  logic                 in_ftdi_wr,
  inout  wire  [DATA_W-1:0]    io_ftdi_data,
  ftdi_fifo_responder_if.slave loc,
  output logic [ERR_W-1:0]     out_err
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned LAT_W = 2;

  ftdi_state_t       state, state_nxt;
  logic              bus_en, bus_en_nxt;
  logic              rd_zero, rd_zero_nxt;
  logic              hold_conf, hold_conf_nxt;
  logic [LAT_W-1:0]  wait_cnt, wait_nxt;
  logic [ERR_W-1:0]  err, err_set;
  logic              txe, rxf, push_ready;
  logic              rx_push, rx_pop_c, rx_full, rx_empty;
  logic              tx_push_c, tx_pop, tx_full, tx_empty;
  logic [CW-1:0]     rx_cnt, tx_cnt, rx_cnt_nxt, tx_cnt_nxt;
  logic [DATA_W-1:0] rx_head, tx_head, bus_out;

  assign rx_push = loc.in_push_valid && push_ready;
  assign tx_pop  = !tx_empty && loc.in_pop_ready;

  ftdi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(in_clk), .rst(in_rst),
    .wr_en(rx_push), .wr_data(loc.in_push_data),
    .rd_en(rx_pop_c), .rd_data(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );

  ftdi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(in_clk), .rst(in_rst),
    .wr_en(tx_push_c), .wr_data(io_ftdi_data),
    .rd_en(tx_pop), .rd_data(tx_head),
    .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );

  // Occupancy after this edge, used to register the flow-control flags.
  assign rx_cnt_nxt = rx_cnt + CW'(rx_push && !rx_full) - CW'(rx_pop_c && !rx_empty);
  assign tx_cnt_nxt = tx_cnt + CW'(tx_push_c && !tx_full) - CW'(tx_pop && !tx_empty);

  // Bus FSM; a conflict parks in WR_HOLD until both strobes are released.
  always_comb begin
    state_nxt     = state;
    bus_en_nxt    = bus_en;
    rd_zero_nxt   = rd_zero;
    hold_conf_nxt = hold_conf;
    wait_nxt      = wait_cnt;
    rx_pop_c      = 1'b0;
    tx_push_c     = 1'b0;
    err_set       = '0;
    if (in_ftdi_rd && in_ftdi_wr) begin
      err_set[ERR_CONFLICT] = 1'b1;
      bus_en_nxt            = 1'b0;
      hold_conf_nxt         = 1'b1;
      state_nxt             = ST_WR_HOLD;
    end else begin
      unique case (state)
        ST_IDLE: begin
          hold_conf_nxt = 1'b0;
          if (in_ftdi_rd) begin
            rd_zero_nxt            = rx_empty;
            err_set[ERR_UNDERFLOW] = rx_empty;
            wait_nxt               = '0;
            if (RD_LAT == 1) begin
              state_nxt  = ST_RD_DRIVE;
              bus_en_nxt = 1'b1;
            end else begin
              state_nxt = ST_RD_WAIT;
            end
          end else if (in_ftdi_wr) begin
            state_nxt = ST_WR_HOLD;
            if (tx_full) err_set[ERR_OVERFLOW] = 1'b1;
            else         tx_push_c             = 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (!in_ftdi_rd) begin
            rx_pop_c  = !rd_zero;
            state_nxt = ST_RD_RECOV;
          end else if (wait_cnt == LAT_W'(RD_LAT - 2)) begin
            state_nxt  = ST_RD_DRIVE;
            bus_en_nxt = 1'b1;
          end else begin
            wait_nxt = wait_cnt + LAT_W'(1);
          end
        end
        ST_RD_DRIVE: begin
          if (!in_ftdi_rd) begin
            rx_pop_c   = !rd_zero;
            bus_en_nxt = 1'b0;
            state_nxt  = ST_RD_RECOV;
          end
        end
        ST_RD_RECOV: state_nxt = ST_IDLE;
        ST_WR_HOLD: begin
          if (!in_ftdi_wr && !(hold_conf && in_ftdi_rd)) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state      <= ST_IDLE;
      bus_en     <= 1'b0;
      rd_zero    <= 1'b0;
      hold_conf  <= 1'b0;
      wait_cnt   <= '0;
      err        <= '0;
      txe        <= 1'b0;
      rxf        <= 1'b0;
      push_ready <= 1'b0;
    end else begin
      state      <= state_nxt;
      bus_en     <= bus_en_nxt;
      rd_zero    <= rd_zero_nxt;
      hold_conf  <= hold_conf_nxt;
      wait_cnt   <= wait_nxt;
      err        <= err | err_set;
      txe        <= (state_nxt == ST_IDLE) && (tx_cnt_nxt != CW'(DEPTH));
      rxf        <= (state_nxt == ST_IDLE) && (rx_cnt_nxt != '0);
      push_ready <= (rx_cnt_nxt != CW'(DEPTH));
    end
  end

  // An empty-FIFO read still runs a full cycle but shows 0x00.
  assign bus_out      = rd_zero ? '0 : rx_head;
  assign io_ftdi_data = bus_en ? bus_out : 'z;

  assign out_ftdi_txe       = txe;
  assign out_ftdi_rxf       = rxf;
  assign out_err            = err;
  assign loc.out_push_ready = push_ready;
  assign loc.out_pop_valid  = !tx_empty;
  assign loc.out_pop_data   = tx_head;

endmodule

// File: tb/tb_ftdi_fifo_responder.sv
// Directed bench for ftdi_fifo_responder: reads, writes, overflow, underflow,
// strobe conflict, reset mid-read and a 256-byte streaming scoreboard.
module tb_ftdi_fifo_responder;
  import ftdi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic       peer_en = 1'b0;
  logic [7:0] peer_data = 8'h00;
  wire  [7:0] ftdi_data;
  logic       txe, rxf;
  logic [2:0] err;
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_fail = 0;

  logic [7:0] sb[$];
  logic [7:0] nxt_b;
  logic [7:0] exp_b;
  int         pushed, got;
  logic       fire, reading;

  ftdi_fifo_responder_if lif ();

  assign ftdi_data = peer_en ? peer_data : 8'hzz;

  ftdi_fifo_responder #(.DEPTH(16), .RD_LAT(1)) dut (
    .in_clk(clk), .in_rst(rst),
    .out_ftdi_txe(txe), .out_ftdi_rxf(rxf),
    .in_ftdi_rd(rd), .in_ftdi_wr(wr),
    .io_ftdi_data(ftdi_data),
    .loc(lif.slave),
    .out_err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Released bus: high-Z in a 4-state simulator, 0 where Z resolves to 0.
  task automatic chk_rel(input string tag, input logic [7:0] obs);
    n_chk++;
    assert ((obs === 8'hzz) || (obs === 8'h00)) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=released", tag, obs);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    lif.in_push_data  = b;
    lif.in_push_valid = 1'b1;
    cyc(1);
    lif.in_push_valid = 1'b0;
  endtask

  // rd high for 5 clocks, bus sampled after the 4th; returns one clock after IDLE.
  task automatic peer_read(input string tag, input logic [7:0] exp);
    rd = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      if (i == 1) chk({tag, "_rxf_low"}, 32'(rxf), 32'd0);
      if (i == 4) chk({tag, "_bus"}, 32'(ftdi_data), 32'(exp));
    end
    rd = 1'b0;
    cyc(1);
    chk({tag, "_recov_rxf"}, 32'(rxf), 32'd0);
    cyc(1);
  endtask

  task automatic peer_write(input logic [7:0] b);
    peer_data = b;
    peer_en   = 1'b1;
    wr        = 1'b1;
    cyc(2);
    wr      = 1'b0;
    peer_en = 1'b0;
    cyc(1);
  endtask

  initial begin
    lif.in_push_data  = 8'h00;
    lif.in_push_valid = 1'b0;
    lif.in_pop_ready  = 1'b0;
    #2 rst = 1'b1;
    cyc(2);
    chk("rst_txe", 32'(txe), 32'd0);
    chk("rst_rxf", 32'(rxf), 32'd0);
    chk("rst_push_ready", 32'(lif.out_push_ready), 32'd0);
    chk("rst_pop_valid", 32'(lif.out_pop_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk_rel("rst_bus", ftdi_data);
    rst = 1'b0;
    cyc(1);
    chk("rel_txe", 32'(txe), 32'd1);
    chk("rel_push_ready", 32'(lif.out_push_ready), 32'd1);
    chk("rel_rxf", 32'(rxf), 32'd0);

    // Two local bytes read back by the peer.
    push_byte(8'hA5);
    chk("push1_rxf", 32'(rxf), 32'd1);
    push_byte(8'h3C);
    peer_read("rd1", 8'hA5);
    chk("rd1_rxf_after", 32'(rxf), 32'd1);
    peer_read("rd2", 8'h3C);
    chk("rd2_rxf_after", 32'(rxf), 32'd0);
    chk("rd2_err", 32'(err), 32'd0);

    // Read with RX empty.
    peer_read("und", 8'h00);
    chk("und_err", 32'(err), 32'b010);
    chk("und_rxf", 32'(rxf), 32'd0);
    chk("und_push_ready", 32'(lif.out_push_ready), 32'd1);
    push_byte(8'h5A);
    peer_read("und_after", 8'h5A);
    chk("und_after_rxf", 32'(rxf), 32'd0);

    // Peer fills TX, then overflows it.
    for (int b = 8'h11; b <= 8'h1F; b++) begin
      peer_write(8'(b));
      chk("wr_txe", 32'(txe), 32'd1);
    end
    chk("wr15_pop_valid", 32'(lif.out_pop_valid), 32'd1);
    chk("wr15_pop_head", 32'(lif.out_pop_data), 32'h11);
    peer_write(8'h20);
    chk("wr16_txe", 32'(txe), 32'd0);
    peer_write(8'h99);
    chk("wr17_err", 32'(err), 32'b011);
    chk("wr17_txe", 32'(txe), 32'd0);
    lif.in_pop_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("pop_valid", 32'(lif.out_pop_valid), 32'd1);
      chk("pop_data", 32'(lif.out_pop_data), 32'(8'h11 + i));
      cyc(1);
    end
    lif.in_pop_ready = 1'b0;
    chk("pop_drained", 32'(lif.out_pop_valid), 32'd0);
    chk("pop_txe", 32'(txe), 32'd1);

    // rd and wr together.
    push_byte(8'hC3);
    chk("conf_pre_rxf", 32'(rxf), 32'd1);
    rd = 1'b1;
    wr = 1'b1;
    cyc(1);
    chk("conf_err", 32'(err), 32'b111);
    chk_rel("conf_bus", ftdi_data);
    chk("conf_rxf", 32'(rxf), 32'd0);
    cyc(1);
    wr = 1'b0;
    cyc(1);
    chk("conf_rd_only_rxf", 32'(rxf), 32'd0);
    chk_rel("conf_rd_only_bus", ftdi_data);
    rd = 1'b0;
    cyc(1);
    chk("conf_idle_rxf", 32'(rxf), 32'd1);
    chk("conf_no_tx_push", 32'(lif.out_pop_valid), 32'd0);
    chk("conf_txe", 32'(txe), 32'd1);
    peer_read("conf_after", 8'hC3);
    chk("conf_after_rxf", 32'(rxf), 32'd0);

    // Reset while the bus is driven.
    push_byte(8'h77);
    rd = 1'b1;
    cyc(3);
    chk("rstrd_bus", 32'(ftdi_data), 32'h77);
    rst = 1'b1;
    #1;
    chk_rel("rstrd_bus_rel", ftdi_data);
    rd = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("rstrd_rxf", 32'(rxf), 32'd0);
    chk("rstrd_txe", 32'(txe), 32'd1);
    chk("rstrd_push_ready", 32'(lif.out_push_ready), 32'd1);
    chk("rstrd_pop_valid", 32'(lif.out_pop_valid), 32'd0);
    chk("rstrd_err", 32'(err), 32'd0);

    // Push every clock while the peer reads as fast as rxf allows.
    nxt_b   = 8'h00;
    pushed  = 0;
    got     = 0;
    fire    = 1'b0;
    reading = 1'b0;
    for (int c = 0; c < 4000 && got < 256; c++) begin
      cyc(1);
      if (fire) begin
        sb.push_back(nxt_b);
        nxt_b++;
        pushed++;
      end
      if (reading) begin
        exp_b = 8'hEE;
        if (sb.size() != 0) exp_b = sb.pop_front();
        chk("stream_byte", 32'(ftdi_data), 32'(exp_b));
        got++;
        rd      = 1'b0;
        reading = 1'b0;
      end else if (rxf) begin
        rd      = 1'b1;
        reading = 1'b1;
      end
      lif.in_push_valid = (pushed < 256);
      lif.in_push_data  = nxt_b;
      fire = lif.in_push_valid && lif.out_push_ready;
    end
    lif.in_push_valid = 1'b0;
    rd = 1'b0;
    cyc(3);
    chk("stream_got", 32'(got), 32'd256);
    chk("stream_pushed", 32'(pushed), 32'd256);
    chk("stream_sb_left", 32'(sb.size()), 32'd0);
    chk("stream_rxf_end", 32'(rxf), 32'd0);
    chk("stream_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ftdi_fifo_responder.md
FTDI_FIFO_RESPONDER -- requirements
Module: ftdi_fifo_responder

Interface
REQ-001 Parameter: DEPTH, 16, entries per FIFO (power of two, 4..256).
REQ-002 Parameter: RD_LAT, 1, clocks from rd sampled high to data driven (1..2).
REQ-003 Port: in_clk  input  1  clock; all logic on rising edge.
REQ-004 Port: in_rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: out_ftdi_txe  output  1  high = peer may write a byte.
REQ-006 Port: out_ftdi_rxf  output  1  high = byte available for peer to read.
REQ-007 Port: in_ftdi_rd  input  1  peer read strobe, active-high.
REQ-008 Port: in_ftdi_wr  input  1  peer write strobe, active-high.
REQ-009 Port: io_ftdi_data  inout  8  shared bus; driven only while the read enable is set, else high-Z.
REQ-010 Port: in_push_data / in_push_valid / out_push_ready  input/input/output  8/1/1  local bytes toward peer (RX FIFO); transfer when valid&&ready.
REQ-011 Port: out_pop_data / out_pop_valid / in_pop_ready  output/output/input  8/1/1  bytes written by peer (TX FIFO); transfer when valid&&ready.
REQ-012 Port: out_err  output  3  sticky flags {conflict, underflow, overflow}.

Function
REQ-013 RX FIFO: push on in_push_valid&&out_push_ready; out_push_ready = !rx_full; simultaneous push and pop SHALL both take effect.
REQ-014 TX FIFO: pop on out_pop_valid&&in_pop_ready; out_pop_valid = !tx_empty; out_pop_data = head, combinational from storage.
REQ-015 Bus FSM states: IDLE, RD_WAIT, RD_DRIVE, RD_RECOV, WR_HOLD.
REQ-016 IDLE->RD_WAIT when rd=1, wr=0, rxf=1; IDLE->WR_HOLD when wr=1, rd=0.
REQ-017 RD_WAIT counts RD_LAT-1 clocks, then enters RD_DRIVE; with RD_LAT=1 it lasts zero clocks (IDLE->RD_DRIVE directly).
REQ-018 In RD_DRIVE the bus enable is set and the bus carries RX head; the head stays stable until rd is sampled low.
REQ-019 At the edge where rd is sampled low in RD_DRIVE or RD_WAIT: pop RX once, clear the bus enable, and enter RD_RECOV.
REQ-020 RD_RECOV lasts exactly 1 clock and then returns to IDLE.
REQ-021 out_ftdi_rxf = !rx_empty && state==IDLE; it is low during RD_* states and for the RD_RECOV clock.
REQ-022 WR_HOLD: at the entry edge, sample the bus and push to TX if !tx_full, else set err.overflow and drop the byte; stay until wr is sampled low, then return to IDLE. Exactly one byte is captured per strobe regardless of strobe length.
REQ-023 out_ftdi_txe = !tx_full && state==IDLE, registered.
REQ-024 rd=1 in IDLE with rx_empty: set err.underflow, drive 0x00 through a normal read cycle, no pop.
REQ-025 rd=1 and wr=1 sampled in the same clock (any state): set err.conflict, release the bus, no FIFO action, and go to IDLE once both are low.
REQ-026 The bus enable is registered and glitch-free; the block never drives the bus while wr=1.
REQ-027 Occupancy counters have log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-028 err bits clear only on reset.

Reset
REQ-029 On in_rst: state=IDLE, FIFOs empty, bus enable=0 (high-Z), txe=0, rxf=0, out_push_ready=0, out_pop_valid=0, err=0; out_pop_data is don't-care.
REQ-030 The first clock after reset release restores txe=1 and out_push_ready=1. Reset mid-strobe aborts the strobe; the peer byte is lost and nothing pops.

Structure
REQ-031 A shared package ftdi_pkg holds the state encoding, the err bit indices, and the DEPTH/RD_LAT defaults.
REQ-032 One sub-module, ftdi_sync_fifo (parameterized width/depth, full/empty/count), is instantiated twice (RX and TX).
REQ-033 The tri-state assign is at top level only.

Verification
REQ-034 Push 0xA5, 0x3C; peer reads with rd high 5 clocks, sampling at clock 4 -> bus reads 0xA5 then 0x3C; rxf is low during each strobe plus 1 clock; afterwards rxf=0 and err=0.
REQ-035 Peer writes 0x11..0x1F (wr high 2 clocks each) with in_pop_ready=0 -> 15 bytes queued, txe stays 1; the 16th write makes txe=0; a 17th write sets err[0] and out_pop order is 0x11..0x1F,0x20.
REQ-036 Peer asserts rd with RX empty -> bus reads 0x00, err[1]=1, FIFO counts unchanged.
REQ-037 rd and wr asserted on the same clock -> err[2]=1, bus high-Z, no push/pop, and IDLE after both drop.
REQ-038 Assert in_rst during RD_DRIVE -> bus high-Z immediately; after release, rxf=0, txe=1, and counts are 0.
REQ-039 Local push every clock concurrent with peer reads at max rate -> no byte loss or duplication over 256 bytes (scoreboard).
